// File: rtl/etapa_id_ex_elastica.sv
// rtl/etapa_id_ex_elastica.sv - elastic ID/EX stage with 2-entry skid buffer, flush and perf counters
module etapa_id_ex_elastica #(
    parameter int ANCHO_DATOS = 32,
    parameter int ANCHO_REG   = 5,
    parameter int ANCHO_CTRL  = 8,
    parameter int ANCHO_CONT  = 16
) (
    input  logic                   clk,
    input  logic                   reinicio,
    input  logic                   valido_entrada,
    output logic                   listo_entrada,
    input  logic [ANCHO_DATOS-1:0] pc_entrada,
    input  logic [ANCHO_DATOS-1:0] registro1_entrada,
    input  logic [ANCHO_DATOS-1:0] registro2_entrada,
    input  logic [ANCHO_DATOS-1:0] extension_signo_entrada,
    input  logic [ANCHO_REG-1:0]   registro_destino_entrada,
    input  logic [ANCHO_CTRL-1:0]  control_entrada,
    input  logic                   vaciado,
    output logic                   valido_salida,
    input  logic                   listo_salida,
    output logic [ANCHO_DATOS-1:0] pc_salida,
    output logic [ANCHO_DATOS-1:0] registro1_salida,
    output logic [ANCHO_DATOS-1:0] registro2_salida,
    output logic [ANCHO_DATOS-1:0] extension_signo_salida,
    output logic [ANCHO_REG-1:0]   registro_destino_salida,
    output logic [ANCHO_CTRL-1:0]  control_salida,
    output logic [1:0]             ocupacion,
    output logic [ANCHO_CONT-1:0]  contador_burbujas,
    output logic [ANCHO_CONT-1:0]  contador_atascos
);

    localparam int ANCHO_PAQ = 4*ANCHO_DATOS + ANCHO_REG + ANCHO_CTRL;
    localparam logic [ANCHO_CONT-1:0] CONT_MAX = '1;

    typedef enum logic [1:0] {
        VACIO = 2'd0,
        UNO   = 2'd1,
        LLENO = 2'd2
    } estado_t;

    estado_t              estado_q, estado_d;
    logic [ANCHO_PAQ-1:0] principal_q, principal_d;
    logic [ANCHO_PAQ-1:0] skid_q, skid_d;
    logic                 listo_q, listo_d;
    logic [ANCHO_CONT-1:0] burbujas_q, burbujas_d;
    logic [ANCHO_CONT-1:0] atascos_q, atascos_d;

    logic [ANCHO_PAQ-1:0] paquete_entrada;
    logic                 entra;
    logic                 sale;
    logic                 valido_q;

    assign paquete_entrada = {pc_entrada, registro1_entrada, registro2_entrada,
                              extension_signo_entrada, registro_destino_entrada,
                              control_entrada};

    assign valido_q = (estado_q != VACIO);
    assign entra    = valido_entrada & listo_q;
    assign sale     = valido_q & listo_salida;

    always_comb begin
        estado_d    = estado_q;
        principal_d = principal_q;
        skid_d      = skid_q;
        case (estado_q)
            VACIO: begin
                if (entra) begin
                    principal_d = paquete_entrada;
                    estado_d    = UNO;
                end
            end
            UNO: begin
                if (sale && entra) begin
                    principal_d = paquete_entrada;
                end else if (sale) begin
                    estado_d = VACIO;
                end else if (entra) begin
                    skid_d   = paquete_entrada;
                    estado_d = LLENO;
                end
            end
            LLENO: begin
                // Skid always drains into main, so it leaves after the older entry.
                if (sale) begin
                    principal_d = skid_q;
                    estado_d    = UNO;
                end
            end
            default: estado_d = VACIO;
        endcase
        if (vaciado) begin
            estado_d    = VACIO;
            principal_d = '0;
            skid_d      = '0;
        end
        listo_d = (estado_d != LLENO);
    end

    always_comb begin
        burbujas_d = burbujas_q;
        atascos_d  = atascos_q;
        if (!valido_q && (burbujas_q != CONT_MAX)) begin
            burbujas_d = burbujas_q + 1'b1;
        end
        if (valido_q && !listo_salida && (atascos_q != CONT_MAX)) begin
            atascos_d = atascos_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reinicio) begin
            estado_q    <= VACIO;
            principal_q <= '0;
            skid_q      <= '0;
            listo_q     <= 1'b1;
            burbujas_q  <= '0;
            atascos_q   <= '0;
        end else begin
            estado_q    <= estado_d;
            principal_q <= principal_d;
            skid_q      <= skid_d;
            listo_q     <= listo_d;
            burbujas_q  <= burbujas_d;
            atascos_q   <= atascos_d;
        end
    end

    assign {pc_salida, registro1_salida, registro2_salida, extension_signo_salida,
            registro_destino_salida, control_salida} = principal_q;

    assign listo_entrada     = listo_q;
    assign valido_salida     = valido_q;
    assign ocupacion         = estado_q;
    assign contador_burbujas = burbujas_q;
    assign contador_atascos  = atascos_q;

endmodule

// File: tb/tb_etapa_id_ex_elastica.sv
// tb/tb_etapa_id_ex_elastica.sv - directed self-checking bench for etapa_id_ex_elastica
module tb_etapa_id_ex_elastica;

    logic        clk = 1'b0;
    logic        reinicio;
    logic        valido_entrada;
    logic        listo_entrada;
    logic [31:0] pc_entrada, registro1_entrada, registro2_entrada, extension_signo_entrada;
    logic [4:0]  registro_destino_entrada;
    logic [7:0]  control_entrada;
    logic        vaciado;
    logic        valido_salida;
    logic        listo_salida;
    logic [31:0] pc_salida, registro1_salida, registro2_salida, extension_signo_salida;
    logic [4:0]  registro_destino_salida;
    logic [7:0]  control_salida;
    logic [1:0]  ocupacion;
    logic [15:0] contador_burbujas, contador_atascos;

    logic        s_listo_entrada, s_valido_salida;
    logic [31:0] s_pc, s_r1, s_r2, s_ext;
    logic [4:0]  s_rd;
    logic [7:0]  s_ctrl;
    logic [1:0]  s_ocup;
    logic [3:0]  s_burbujas, s_atascos;

    int comparados = 0;
    int fallos     = 0;
    logic [15:0] atascos_base;

    always #5 clk = ~clk;

    etapa_id_ex_elastica dut (
        .clk(clk), .reinicio(reinicio),
        .valido_entrada(valido_entrada), .listo_entrada(listo_entrada),
        .pc_entrada(pc_entrada), .registro1_entrada(registro1_entrada),
        .registro2_entrada(registro2_entrada), .extension_signo_entrada(extension_signo_entrada),
        .registro_destino_entrada(registro_destino_entrada), .control_entrada(control_entrada),
        .vaciado(vaciado), .valido_salida(valido_salida), .listo_salida(listo_salida),
        .pc_salida(pc_salida), .registro1_salida(registro1_salida),
        .registro2_salida(registro2_salida), .extension_signo_salida(extension_signo_salida),
        .registro_destino_salida(registro_destino_salida), .control_salida(control_salida),
        .ocupacion(ocupacion), .contador_burbujas(contador_burbujas),
        .contador_atascos(contador_atascos)
    );

    etapa_id_ex_elastica #(.ANCHO_CONT(4)) dut_sat (
        .clk(clk), .reinicio(reinicio),
        .valido_entrada(valido_entrada), .listo_entrada(s_listo_entrada),
        .pc_entrada(pc_entrada), .registro1_entrada(registro1_entrada),
        .registro2_entrada(registro2_entrada), .extension_signo_entrada(extension_signo_entrada),
        .registro_destino_entrada(registro_destino_entrada), .control_entrada(control_entrada),
        .vaciado(vaciado), .valido_salida(s_valido_salida), .listo_salida(listo_salida),
        .pc_salida(s_pc), .registro1_salida(s_r1),
        .registro2_salida(s_r2), .extension_signo_salida(s_ext),
        .registro_destino_salida(s_rd), .control_salida(s_ctrl),
        .ocupacion(s_ocup), .contador_burbujas(s_burbujas),
        .contador_atascos(s_atascos)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chequear(input string tag, input logic [63:0] obs, input logic [63:0] esp);
        comparados++;
        assert (obs === esp) else begin
            fallos++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, esp);
        end
    endtask

    task automatic enviar(input logic v, input logic [31:0] pc);
        valido_entrada           = v;
        pc_entrada               = pc;
        registro1_entrada        = pc + 32'd1;
        registro2_entrada        = pc + 32'd2;
        extension_signo_entrada  = pc + 32'd3;
        registro_destino_entrada = pc[6:2];
        control_entrada          = pc[7:0] ^ 8'hA5;
    endtask

    task automatic chequear_campos(input string tag, input logic [31:0] pc);
        logic [31:0] tmp;
        tmp = pc;
        chequear({tag, "_pc"}, pc_salida, pc);
        chequear({tag, "_r1"}, registro1_salida, pc + 32'd1);
        chequear({tag, "_r2"}, registro2_salida, pc + 32'd2);
        chequear({tag, "_ext"}, extension_signo_salida, pc + 32'd3);
        chequear({tag, "_rd"}, registro_destino_salida, tmp[6:2]);
        chequear({tag, "_ctrl"}, control_salida, tmp[7:0] ^ 8'hA5);
    endtask

    task automatic chequear_ceros(input string tag);
        chequear({tag, "_valido"}, valido_salida, 1'b0);
        chequear({tag, "_datos"}, {pc_salida, registro1_salida, registro2_salida,
                                   extension_signo_salida, registro_destino_salida,
                                   control_salida} == '0, 1'b1);
        chequear({tag, "_ocup"}, ocupacion, 2'd0);
        chequear({tag, "_listo"}, listo_entrada, 1'b1);
    endtask

    initial begin
        // Reset with random inputs
        reinicio     = 1'b0;
        vaciado      = 1'($urandom);
        listo_salida = 1'($urandom);
        enviar(1'b1, $urandom);
        tick();
        enviar(1'b1, $urandom);
        tick();
        chequear_ceros("rst");
        chequear("rst_burb", contador_burbujas, 16'd0);
        chequear("rst_atas", contador_atascos, 16'd0);

        reinicio     = 1'b1;
        vaciado      = 1'b0;
        listo_salida = 1'b0;
        enviar(1'b0, 32'h0);
        repeat (3) tick();
        chequear("idle_burb3", contador_burbujas, 16'd3);

        // Streaming
        listo_salida = 1'b1;
        enviar(1'b1, 32'h100);
        tick();
        chequear("st0_valido", valido_salida, 1'b1);
        chequear("st0_ocup", ocupacion, 2'd1);
        chequear_campos("st0", 32'h100);
        enviar(1'b1, 32'h104);
        tick();
        chequear("st1_valido", valido_salida, 1'b1);
        chequear("st1_ocup", ocupacion, 2'd1);
        chequear_campos("st1", 32'h104);
        enviar(1'b1, 32'h108);
        tick();
        chequear("st2_valido", valido_salida, 1'b1);
        chequear("st2_ocup", ocupacion, 2'd1);
        chequear_campos("st2", 32'h108);
        enviar(1'b0, 32'h0);
        tick();
        chequear("st_drain_valido", valido_salida, 1'b0);
        chequear("st_drain_ocup", ocupacion, 2'd0);
        chequear("st_burb4", contador_burbujas, 16'd4);

        // Backpressure
        listo_salida = 1'b0;
        enviar(1'b1, 32'h200);
        tick();
        chequear("bp0_ocup", ocupacion, 2'd1);
        chequear("bp0_listo", listo_entrada, 1'b1);
        enviar(1'b1, 32'h204);
        tick();
        chequear("bp1_ocup", ocupacion, 2'd2);
        chequear("bp1_listo", listo_entrada, 1'b0);
        chequear_campos("bp1", 32'h200);
        chequear("bp1_atas", contador_atascos, 16'd1);
        atascos_base = contador_atascos;
        enviar(1'b1, 32'h208);
        repeat (3) tick();
        chequear("bp_atas_plus3", contador_atascos, atascos_base + 16'd3);
        chequear("bp_hold_ocup", ocupacion, 2'd2);
        chequear_campos("bp_hold", 32'h200);
        listo_salida = 1'b1;
        enviar(1'b0, 32'h0);
        tick();
        chequear("bp_out1_valido", valido_salida, 1'b1);
        chequear("bp_out1_ocup", ocupacion, 2'd1);
        chequear("bp_out1_listo", listo_entrada, 1'b1);
        chequear_campos("bp_out1", 32'h204);
        tick();
        chequear("bp_out2_valido", valido_salida, 1'b0);
        chequear("bp_out2_ocup", ocupacion, 2'd0);

        // Flush while full, incoming instruction present
        listo_salida = 1'b0;
        enviar(1'b1, 32'h280);
        tick();
        enviar(1'b1, 32'h284);
        tick();
        chequear("fl_pre_ocup", ocupacion, 2'd2);
        vaciado = 1'b1;
        enviar(1'b1, 32'h300);
        tick();
        chequear_ceros("fl_full");
        vaciado      = 1'b0;
        listo_salida = 1'b1;
        enviar(1'b0, 32'h0);
        tick();
        chequear("fl_no300_valido", valido_salida, 1'b0);
        chequear("fl_no300_pc", pc_salida, 32'h0);

        // Flush in UNO discards same-cycle accepted input
        listo_salida = 1'b0;
        enviar(1'b1, 32'h400);
        tick();
        chequear("fl1_pre_ocup", ocupacion, 2'd1);
        vaciado = 1'b1;
        enviar(1'b1, 32'h404);
        tick();
        chequear_ceros("fl_uno");
        vaciado = 1'b0;
        enviar(1'b0, 32'h0);
        tick();
        chequear("fl_uno_after", valido_salida, 1'b0);

        // Reset while full with flush asserted
        enviar(1'b1, 32'h500);
        tick();
        enviar(1'b1, 32'h504);
        tick();
        chequear("rst2_pre_ocup", ocupacion, 2'd2);
        reinicio = 1'b0;
        vaciado  = 1'b1;
        tick();
        chequear_ceros("rst2");
        chequear("rst2_burb", contador_burbujas, 16'd0);
        chequear("rst2_atas", contador_atascos, 16'd0);
        chequear("rst2_sat_burb", s_burbujas, 4'd0);

        // Saturation on the 4-bit instance
        reinicio = 1'b1;
        vaciado  = 1'b0;
        enviar(1'b0, 32'h0);
        repeat (20) tick();
        chequear("sat_burb15", s_burbujas, 4'd15);
        chequear("wide_burb20", contador_burbujas, 16'd20);
        repeat (2) tick();
        chequear("sat_burb_stay15", s_burbujas, 4'd15);
        chequear("wide_burb22", contador_burbujas, 16'd22);
        chequear("sat_atas0", s_atascos, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", comparados, fallos);
        $finish;
    end

endmodule
